// File: rtl/reg_writeback.sv
// Register-file write port: merges 1-cycle ALU results with queued load results,
// preserving architectural order and reporting outstanding writes to decode.
module reg_writeback #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic              i_clock,
    input  logic              i_nreset,
    input  logic              i_alu_valid,
    input  logic [4:0]        i_alu_rd,
    input  logic [DWIDTH-1:0] i_alu_data,
    input  logic              i_ld_valid,
    output logic              o_ld_ready,
    input  logic [4:0]        i_ld_rd,
    input  logic [DWIDTH-1:0] i_ld_data,
    input  logic [4:0]        i_qr1,
    input  logic [4:0]        i_qr2,
    output logic              o_pend1,
    output logic              o_pend2,
    output logic              o_regw,
    output logic [4:0]        o_waddr,
    output logic [DWIDTH-1:0] o_wdata
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [4:0]        r_rd   [DEPTH];
    logic [DWIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_kill;

    logic              r_regw;
    logic [4:0]        r_waddr;
    logic [DWIDTH-1:0] r_wdata;

    logic              w_alu_wr;
    logic              w_ld_ready;
    logic              w_push;
    logic              w_empty;
    logic              w_pop;
    logic              w_head_kill;
    logic [DEPTH-1:0]  w_live;
    logic [DEPTH-1:0]  w_hit1;
    logic [DEPTH-1:0]  w_hit2;

    assign w_alu_wr    = i_alu_valid && (i_alu_rd != 5'd0);
    assign w_ld_ready  = (r_count != CW'(DEPTH));
    assign w_push      = i_ld_valid && w_ld_ready && (i_ld_rd != 5'd0);
    assign w_empty     = (r_count == '0);
    // An accepted ALU result owns the write port; the FIFO only drains on ALU-idle cycles.
    assign w_pop       = !w_alu_wr && !w_empty;
    assign w_head_kill = r_kill[r_rd_ptr];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic [PW-1:0] w_off;
            // Slot distance from head, modulo DEPTH, tells whether the slot is occupied.
            assign w_off      = PW'(gi) - r_rd_ptr;
            assign w_live[gi] = (CW'(w_off) < r_count) && !r_kill[gi];
            assign w_hit1[gi] = w_live[gi] && (r_rd[gi] == i_qr1);
            assign w_hit2[gi] = w_live[gi] && (r_rd[gi] == i_qr2);
        end
    endgenerate

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A same-edge ALU write to the same rd is younger, so a newly pushed entry can be born killed.
    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_kill <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr == PW'(i))) begin
                    r_rd[i]   <= i_ld_rd;
                    r_data[i] <= i_ld_data;
                    r_kill[i] <= w_alu_wr && (i_ld_rd == i_alu_rd);
                end else if (w_alu_wr && (r_rd[i] == i_alu_rd)) begin
                    r_kill[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_regw  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_alu_wr) begin
            r_regw  <= 1'b1;
            r_waddr <= i_alu_rd;
            r_wdata <= i_alu_data;
        end else if (!w_empty) begin
            r_regw <= !w_head_kill;
            if (!w_head_kill) begin
                r_waddr <= r_rd[r_rd_ptr];
                r_wdata <= r_data[r_rd_ptr];
            end
        end else begin
            r_regw <= 1'b0;
        end
    end

    assign o_ld_ready = w_ld_ready;
    assign o_regw     = r_regw;
    assign o_waddr    = r_waddr;
    assign o_wdata    = r_wdata;
    assign o_pend1    = (i_qr1 != 5'd0) && ((r_regw && (r_waddr == i_qr1)) || (|w_hit1));
    assign o_pend2    = (i_qr2 != 5'd0) && ((r_regw && (r_waddr == i_qr2)) || (|w_hit2));

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_reg_writeback;
    localparam int DWIDTH = 32;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              nreset;
    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [DWIDTH-1:0] alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [4:0]        ld_rd;
    logic [DWIDTH-1:0] ld_data;
    logic [4:0]        qr1;
    logic [4:0]        qr2;
    logic              pend1;
    logic              pend2;
    logic              regw;
    logic [4:0]        waddr;
    logic [DWIDTH-1:0] wdata;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    reg_writeback #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
        .i_clock    (clk),
        .i_nreset   (nreset),
        .i_alu_valid(alu_valid),
        .i_alu_rd   (alu_rd),
        .i_alu_data (alu_data),
        .i_ld_valid (ld_valid),
        .o_ld_ready (ld_ready),
        .i_ld_rd    (ld_rd),
        .i_ld_data  (ld_data),
        .i_qr1      (qr1),
        .i_qr2      (qr2),
        .o_pend1    (pend1),
        .o_pend2    (pend2),
        .o_regw     (regw),
        .o_waddr    (waddr),
        .o_wdata    (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the load FIFO as a plain queue of pending writes.
    typedef struct packed {
        logic [4:0]        rd;
        logic [DWIDTH-1:0] data;
        logic              kill;
    } ent_t;

    ent_t              mq[$];
    logic              m_regw  = 1'b0;
    logic [4:0]        m_waddr = '0;
    logic [DWIDTH-1:0] m_wdata = '0;
    bit                m_alu_wr;
    bit                m_push;
    ent_t              m_head;

    function automatic bit m_pend(logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        if (m_regw && m_waddr == q) return 1'b1;
        foreach (mq[i]) if (!mq[i].kill && mq[i].rd == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge nreset);
            if (!nreset) begin
                mq.delete();
                m_regw  = 1'b0;
                m_waddr = '0;
                m_wdata = '0;
            end else begin
                m_alu_wr = alu_valid && alu_rd != 5'd0;
                m_push   = ld_valid && mq.size() < DEPTH && ld_rd != 5'd0;
                if (m_alu_wr) begin
                    m_regw  = 1'b1;
                    m_waddr = alu_rd;
                    m_wdata = alu_data;
                    foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].kill = 1'b1;
                end else if (mq.size() > 0) begin
                    m_head = mq.pop_front();
                    m_regw = !m_head.kill;
                    if (!m_head.kill) begin
                        m_waddr = m_head.rd;
                        m_wdata = m_head.data;
                    end
                end else begin
                    m_regw = 1'b0;
                end
                if (m_push) mq.push_back({ld_rd, ld_data, m_alu_wr && (ld_rd == alu_rd)});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_regw",     32'(regw),     32'(m_regw));
                check("model_waddr",    32'(waddr),    32'(m_waddr));
                check("model_wdata",    wdata,         m_wdata);
                check("model_ld_ready", 32'(ld_ready), 32'(mq.size() != DEPTH));
                check("model_pend1",    32'(pend1),    32'(m_pend(qr1)));
                check("model_pend2",    32'(pend2),    32'(m_pend(qr2)));
                $display("[TB] cyc t=%0t regw=%0b waddr=%0d wdata=%0h rdy=%0b p1=%0b p2=%0b",
                         $time, regw, waddr, wdata, ld_ready, pend1, pend2);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_rd     = '0;
        ld_data   = '0;
    endtask

    task automatic expect_w(input string name, input logic e_regw, input logic [4:0] e_waddr,
                            input logic [31:0] e_wdata);
        check({name, "_regw"},  32'(regw),  32'(e_regw));
        check({name, "_waddr"}, 32'(waddr), 32'(e_waddr));
        check({name, "_wdata"}, wdata,      e_wdata);
    endtask

    initial begin
        nreset = 1'b0;
        qr1    = '0;
        qr2    = '0;
        idle();
        step();
        step();
        expect_w("reset", 1'b0, 5'd0, 32'h0);
        check("reset_ld_ready", 32'(ld_ready), 32'd1);
        check("reset_pend1", 32'(pend1), 32'd0);
        nreset = 1'b1;
        chk_en = 1'b1;
        step();

        // ALU only, then rd=0 treated as no result
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        expect_w("alu5", 1'b1, 5'd5, 32'hDEADBEEF);
        alu_rd = 5'd0; alu_data = 32'h12345678;
        step();
        expect_w("alu0", 1'b0, 5'd5, 32'hDEADBEEF);
        idle();
        step();

        // Load drain: first write two cycles after push
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
        step();
        check("ld_lat_regw", 32'(regw), 32'd0);
        ld_rd = 5'd4; ld_data = 32'h22;
        step();
        expect_w("ld3", 1'b1, 5'd3, 32'h11);
        idle();
        step();
        expect_w("ld4", 1'b1, 5'd4, 32'h22);
        step();
        check("ld_done_regw", 32'(regw), 32'd0);

        // Priority/kill: same-edge ALU to r7 kills queued load to r7
        qr1 = 5'd7;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hAA;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hBB;
        step();
        expect_w("kill_alu", 1'b1, 5'd7, 32'hBB);
        check("kill_pend1_hi", 32'(pend1), 32'd1);
        idle();
        step();
        expect_w("kill_bubble", 1'b0, 5'd7, 32'hBB);
        check("kill_pend1_lo", 32'(pend1), 32'd0);
        step();
        qr1 = '0;

        // Full: ALU busy while four loads queue up
        for (int k = 0; k < DEPTH; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + k); alu_data = 32'h100 + 32'(k);
            ld_valid  = 1'b1; ld_rd  = 5'(20 + k); ld_data  = 32'h200 + 32'(k);
            step();
            check("full_alu_waddr", 32'(waddr), 32'(10 + k));
        end
        check("full_ready0", 32'(ld_ready), 32'd0);
        alu_rd = 5'd14; alu_data = 32'h104;
        ld_rd  = 5'd30; ld_data  = 32'h300;
        step();
        check("full_ready_hold", 32'(ld_ready), 32'd0);
        idle();
        step();
        expect_w("full_pop20", 1'b1, 5'd20, 32'h200);
        check("full_ready1", 32'(ld_ready), 32'd1);
        for (int k = 1; k < DEPTH; k++) begin
            step();
            expect_w("full_pop", 1'b1, 5'(20 + k), 32'h200 + 32'(k));
        end
        step();
        check("full_empty_regw", 32'(regw), 32'd0);

        // Hazard tracking on r9
        qr1 = 5'd9; qr2 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        ld_valid  = 1'b1; ld_rd  = 5'd9; ld_data  = 32'h99;
        step();
        check("haz_q_pend1", 32'(pend1), 32'd1);
        check("haz_pend2", 32'(pend2), 32'd0);
        ld_valid = 1'b0; alu_rd = 5'd2; alu_data = 32'h2;
        step();
        check("haz_q2_pend1", 32'(pend1), 32'd1);
        idle();
        step();
        expect_w("haz_w9", 1'b1, 5'd9, 32'h99);
        check("haz_w_pend1", 32'(pend1), 32'd1);
        step();
        check("haz_done_pend1", 32'(pend1), 32'd0);
        qr1 = '0;

        // Reset mid-stream with three loads queued
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(11 + k); alu_data = 32'h500 + 32'(k);
            ld_valid  = 1'b1; ld_rd  = 5'(14 + k); ld_data  = 32'h600 + 32'(k);
            step();
        end
        idle();
        qr1 = 5'd14;
        #1;
        check("pre_rst_pend1", 32'(pend1), 32'd1);
        nreset = 1'b0;
        #1;
        expect_w("midrst", 1'b0, 5'd0, 32'h0);
        check("midrst_ready", 32'(ld_ready), 32'd1);
        check("midrst_pend1", 32'(pend1), 32'd0);
        step();
        step();
        nreset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("post_rst_regw", 32'(regw), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
